// File: rtl/drawbridge_sensor_front.sv
// Sensor front-end for the drawbridge controller: synchronizes and debounces the raw
// loop/radar sensors, emits car pulses, tracks the boat with a Moore FSM, flags barrier violations.
module drawbridge_sensor_front #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DB_W            = 3,
    parameter int unsigned BOAT_HOLD       = 8,
    parameter int unsigned HOLD_W          = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_loopEntry,
    input  logic       i_loopExit,
    input  logic       i_radarFar,
    input  logic       i_radarBridge,
    input  logic       i_carBarrier,
    output logic       o_carIn,
    output logic       o_carOut,
    output logic       o_boatClose,
    output logic       o_boatHere,
    output logic       o_violation,
    output logic [1:0] o_boat_state
);

    localparam int unsigned N_IN      = 4;
    localparam int unsigned N_EDGE    = 3;
    localparam int unsigned IX_ENTRY  = 0;
    localparam int unsigned IX_EXIT   = 1;
    localparam int unsigned IX_FAR    = 2;
    localparam int unsigned IX_BRIDGE = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        APPROACH = 2'b01,
        PASSING  = 2'b10,
        CLEARING = 2'b11
    } boat_state_t;

    logic [N_IN-1:0]   raw;
    logic [N_IN-1:0]   sync1;
    logic [N_IN-1:0]   sync2;
    logic [N_IN-1:0]   filt;
    logic [DB_W-1:0]   db_cnt [N_IN];
    logic [N_EDGE-1:0] edge_q;
    logic [N_EDGE-1:0] rise;

    boat_state_t       state;
    boat_state_t       state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;

    assign raw = {i_radarBridge, i_radarFar, i_loopExit, i_loopEntry};

    // Two-flop synchronizer for the asynchronous field sensors
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: filtered value follows only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            filt <= '0;
            for (int i = 0; i < int'(N_IN); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_IN); i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] + DB_W'(1) == DB_W'(DEBOUNCE_CYCLES)) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise = filt[N_EDGE-1:0] & ~edge_q;

    // Registered car pulses and sticky barrier violation
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            edge_q      <= '0;
            o_carIn     <= 1'b0;
            o_carOut    <= 1'b0;
            o_violation <= 1'b0;
        end else begin
            edge_q   <= filt[N_EDGE-1:0];
            o_carIn  <= rise[IX_ENTRY] & ~i_carBarrier;
            o_carOut <= rise[IX_EXIT];
            if (rise[IX_ENTRY] && i_carBarrier) begin
                o_violation <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // Boat tracking; the under-bridge sensor always wins over the far radar
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            IDLE: begin
                if (filt[IX_BRIDGE]) begin
                    state_next = PASSING;
                end else if (rise[IX_FAR]) begin
                    state_next = APPROACH;
                end
            end
            APPROACH: begin
                if (filt[IX_BRIDGE]) begin
                    state_next = PASSING;
                end else if (!filt[IX_FAR]) begin
                    state_next = IDLE;
                end
            end
            PASSING: begin
                if (!filt[IX_BRIDGE]) begin
                    state_next = CLEARING;
                    hold_next  = HOLD_W'(BOAT_HOLD);
                end
            end
            CLEARING: begin
                if (filt[IX_BRIDGE]) begin
                    state_next = PASSING;
                end else begin
                    hold_next = hold_cnt - HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(1)) begin
                        state_next = filt[IX_FAR] ? APPROACH : IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_boat_state = state;
    assign o_boatClose  = (state != IDLE);
    assign o_boatHere   = state[1];

endmodule

// File: tb/tb_drawbridge_sensor_front.sv
// Scoreboard bench for drawbridge_sensor_front: stimulus queues timed expected events,
// a negedge monitor pops and compares whenever a pulse, state change or violation change appears.
module tb_drawbridge_sensor_front;

    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_loopEntry;
    logic       i_loopExit;
    logic       i_radarFar;
    logic       i_radarBridge;
    logic       i_carBarrier;
    logic       o_carIn;
    logic       o_carOut;
    logic       o_boatClose;
    logic       o_boatHere;
    logic       o_violation;
    logic [1:0] o_boat_state;

    typedef struct {
        int   cyc;
        logic cin;
        logic cout;
    } car_ev_t;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       close;
        logic       here;
    } boat_ev_t;

    typedef struct {
        int   cyc;
        logic v;
    } viol_ev_t;

    car_ev_t  car_q[$];
    boat_ev_t boat_q[$];
    viol_ev_t viol_q[$];

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       mon_en   = 1'b0;
    logic [1:0] prev_state = 2'b00;
    logic       prev_viol  = 1'b0;

    drawbridge_sensor_front dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_loopEntry  (i_loopEntry),
        .i_loopExit   (i_loopExit),
        .i_radarFar   (i_radarFar),
        .i_radarBridge(i_radarBridge),
        .i_carBarrier (i_carBarrier),
        .o_carIn      (o_carIn),
        .o_carOut     (o_carOut),
        .o_boatClose  (o_boatClose),
        .o_boatHere   (o_boatHere),
        .o_violation  (o_violation),
        .o_boat_state (o_boat_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void exp_car(input int c, input logic ci, input logic co);
        car_ev_t e;
        e.cyc = c; e.cin = ci; e.cout = co;
        car_q.push_back(e);
    endfunction

    function automatic void exp_boat(input int c, input logic [1:0] st, input logic cl, input logic hr);
        boat_ev_t e;
        e.cyc = c; e.st = st; e.close = cl; e.here = hr;
        boat_q.push_back(e);
    endfunction

    function automatic void exp_viol(input int c, input logic v);
        viol_ev_t e;
        e.cyc = c; e.v = v;
        viol_q.push_back(e);
    endfunction

    // Monitor: every visible output event must match the head of its queue, cycle included
    always @(negedge clk) begin
        car_ev_t  ce;
        boat_ev_t be;
        viol_ev_t ve;
        if (mon_en) begin
            if (o_carIn !== 1'b0 || o_carOut !== 1'b0) begin
                checks++;
                if (car_q.size() == 0) begin
                    failures++;
                    $display("FAIL car_pulse: unexpected in=%b out=%b at cycle %0d", o_carIn, o_carOut, cyc);
                end else begin
                    ce = car_q.pop_front();
                    if (ce.cyc != cyc || ce.cin !== o_carIn || ce.cout !== o_carOut) begin
                        failures++;
                        $display("FAIL car_pulse: got in=%b out=%b at cycle %0d, expected in=%b out=%b at cycle %0d",
                                 o_carIn, o_carOut, cyc, ce.cin, ce.cout, ce.cyc);
                    end
                end
            end
            if (o_boat_state !== prev_state) begin
                checks++;
                if (boat_q.size() == 0) begin
                    failures++;
                    $display("FAIL boat_state: unexpected change to %b at cycle %0d", o_boat_state, cyc);
                end else begin
                    be = boat_q.pop_front();
                    if (be.cyc != cyc || be.st !== o_boat_state || be.close !== o_boatClose || be.here !== o_boatHere) begin
                        failures++;
                        $display("FAIL boat_state: got st=%b close=%b here=%b at cycle %0d, expected st=%b close=%b here=%b at cycle %0d",
                                 o_boat_state, o_boatClose, o_boatHere, cyc, be.st, be.close, be.here, be.cyc);
                    end
                end
                prev_state = o_boat_state;
            end
            if (o_violation !== prev_viol) begin
                checks++;
                if (viol_q.size() == 0) begin
                    failures++;
                    $display("FAIL violation: unexpected change to %b at cycle %0d", o_violation, cyc);
                end else begin
                    ve = viol_q.pop_front();
                    if (ve.cyc != cyc || ve.v !== o_violation) begin
                        failures++;
                        $display("FAIL violation: got %b at cycle %0d, expected %b at cycle %0d",
                                 o_violation, cyc, ve.v, ve.cyc);
                    end
                end
                prev_viol = o_violation;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_carIn"},     32'(o_carIn),      32'd0);
        check({tag, "_carOut"},    32'(o_carOut),     32'd0);
        check({tag, "_boatClose"}, 32'(o_boatClose),  32'd0);
        check({tag, "_boatHere"},  32'(o_boatHere),   32'd0);
        check({tag, "_violation"}, 32'(o_violation),  32'd0);
        check({tag, "_state"},     32'(o_boat_state), 32'd0);
    endtask

    initial begin
        int t;
        int g;
        i_reset       = 1'b1;
        i_loopEntry   = 1'b0;
        i_loopExit    = 1'b0;
        i_radarFar    = 1'b0;
        i_radarBridge = 1'b0;
        i_carBarrier  = 1'b0;
        step(3);
        check_all_zero("reset");
        mon_en  = 1'b1;
        i_reset = 1'b0;
        step(2);

        // Single car entry, barrier up
        t = cyc; i_loopEntry = 1'b1; exp_car(t + LAT, 1'b1, 1'b0);
        step(10); i_loopEntry = 1'b0;
        step(14);

        // Three-cycle glitch is filtered out
        i_loopEntry = 1'b1; step(3); i_loopEntry = 1'b0;
        step(12);

        // Entry with barrier down raises the sticky violation
        i_carBarrier = 1'b1;
        t = cyc; i_loopEntry = 1'b1; exp_viol(t + LAT, 1'b1);
        step(10); i_loopEntry = 1'b0;
        step(12); i_carBarrier = 1'b0;
        step(5);
        check("violation_sticky", 32'(o_violation), 32'd1);

        // Boat approach, pass, clear with far still set, then leave
        t = cyc; i_radarFar = 1'b1; exp_boat(t + LAT, 2'b01, 1'b1, 1'b0);
        step(12);
        t = cyc; i_radarBridge = 1'b1; exp_boat(t + LAT, 2'b10, 1'b1, 1'b1);
        step(12);
        t = cyc; i_radarBridge = 1'b0;
        exp_boat(t + LAT, 2'b11, 1'b1, 1'b1);
        exp_boat(t + LAT + 8, 2'b01, 1'b1, 1'b0);
        step(20);
        t = cyc; i_radarFar = 1'b0; exp_boat(t + LAT, 2'b00, 1'b0, 1'b0);
        step(12);

        // Retrigger during CLEARING keeps here asserted
        t = cyc; i_radarBridge = 1'b1; exp_boat(t + LAT, 2'b10, 1'b1, 1'b1);
        step(12);
        t = cyc; i_radarBridge = 1'b0; exp_boat(t + LAT, 2'b11, 1'b1, 1'b1);
        step(5); i_radarBridge = 1'b1; exp_boat(t + 12, 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1);
            check("retrigger_here", 32'(o_boatHere), 32'd1);
        end
        step(2);
        t = cyc; i_radarBridge = 1'b0;
        exp_boat(t + LAT, 2'b11, 1'b1, 1'b1);
        exp_boat(t + LAT + 8, 2'b00, 1'b0, 1'b0);
        step(20);

        // Entry and exit rising together
        t = cyc; i_loopEntry = 1'b1; i_loopExit = 1'b1; exp_car(t + LAT, 1'b1, 1'b1);
        step(10); i_loopEntry = 1'b0; i_loopExit = 1'b0;
        step(14);

        // Reset mid-CLEARING with entry held high
        t = cyc; i_radarBridge = 1'b1; exp_boat(t + LAT, 2'b10, 1'b1, 1'b1);
        step(12);
        g = cyc; i_radarBridge = 1'b0; exp_boat(g + LAT, 2'b11, 1'b1, 1'b1);
        step(8); i_loopEntry = 1'b1;
        step(2);
        i_reset = 1'b1;
        exp_boat(g + 11, 2'b00, 1'b0, 1'b0);
        exp_viol(g + 11, 1'b0);
        step(1);
        check_all_zero("midreset");
        i_reset = 1'b0;
        exp_car(cyc + LAT, 1'b1, 1'b0);
        step(12); i_loopEntry = 1'b0;
        step(14);

        check("car_q_drained",  32'(car_q.size()),  32'd0);
        check("boat_q_drained", 32'(boat_q.size()), 32'd0);
        check("viol_q_drained", 32'(viol_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drawbridge_sensor_front.md
# drawbridge_sensor_front

Sensor front-end that produces the event inputs consumed by the `drawbridge` controller. It synchronizes and debounces the raw vehicle-loop and boat-radar sensors. It then emits single-cycle car entry/exit pulses and the level signals for "boat close" and "boat under bridge". It also flags cars entering while the controller's barrier is down. It sits between the field sensors and `drawbridge`: `o_carIn`, `o_carOut`, `o_boatClose` and `o_boatHere` drive `i_carIn`, `i_carOut`, `i_boatClose` and `i_boatHere`, and `o_carBarrier` returns as `i_carBarrier`.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a filtered input changes (≥1)
- DB_W, 3, debounce counter width; must hold DEBOUNCE_CYCLES
- BOAT_HOLD, 8, cycles `o_boatHere` is held after the under-bridge sensor clears (≥1)
- HOLD_W, 4, hold counter width; must hold BOAT_HOLD

Ports:
- i_clk  in  1  single clock; all logic on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_loopEntry  in  1  raw entry loop sensor, asynchronous
- i_loopExit  in  1  raw exit loop sensor, asynchronous
- i_radarFar  in  1  raw far-zone boat radar, asynchronous
- i_radarBridge  in  1  raw under-bridge boat sensor, asynchronous
- i_carBarrier  in  1  barrier-down level from the controller
- o_carIn  out  1  one-cycle pulse per admitted car
- o_carOut  out  1  one-cycle pulse per departing car
- o_boatClose  out  1  level: a boat is approaching or passing
- o_boatHere  out  1  level: a boat is under or clearing the bridge
- o_violation  out  1  sticky: a car entered while the barrier was down
- o_boat_state  out  2  boat FSM state, for debug

## Operation
- Each raw input passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: the counter clears whenever the synchronized value equals the filtered value.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the filtered value takes the synchronized value and the counter clears.
- Car pulses are registered rising-edge detects on the filtered loop signals.
  - Entry rise with `i_carBarrier`=0 (sampled in the detect cycle): `o_carIn`=1 for one cycle.
  - Entry rise with `i_carBarrier`=1: no `o_carIn`; `o_violation` sets and stays set until reset.
  - Exit rise: `o_carOut`=1 for one cycle, independent of the barrier.
  - Entry and exit rises in the same cycle produce both pulses in the same cycle.
  - Falling edges produce nothing.
- Boat FSM (Moore; outputs decode from the state register):
  - IDLE=00: close=0, here=0.
    - Filtered bridge=1 → PASSING (takes priority).
    - Else filtered far rise → APPROACH.
  - APPROACH=01: close=1, here=0.
    - Bridge=1 → PASSING.
    - Else far=0 → IDLE (boat turned away).
  - PASSING=10: close=1, here=1.
    - Bridge=0 → CLEARING; the hold counter loads BOAT_HOLD.
  - CLEARING=11: close=1, here=1.
    - Bridge=1 → PASSING (retrigger).
    - Else the counter decrements. On the cycle it reaches 0, go to APPROACH if far=1, otherwise IDLE.
- Reset: the state is IDLE. All synchronizers, filtered values, counters, pulses and `o_violation` are 0, so every output reads 0. A pending debounce is discarded.
  - A sensor held high through reset release is detected as a fresh rise after full latency. For example, a car parked on the entry loop yields one `o_carIn`.

## Timing
- Let edge k be the first edge that samples a raw input at its new value, with the input held stable.
  - Synchronizer output changes after edge k+1.
  - Filtered value changes after edge k+1+DEBOUNCE_CYCLES.
  - The pulse or FSM state is registered after edge k+2+DEBOUNCE_CYCLES. With defaults, that is edge k+6.
- A raw pulse or glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output produces no filtered change, no pulse and no state change.
- CLEARING lasts exactly BOAT_HOLD cycles when no retrigger occurs. `o_boatHere` therefore stays high BOAT_HOLD cycles after PASSING exits.
- `o_carIn` and `o_carOut` are never high for more than one consecutive cycle per rising edge. A new pulse requires the filtered signal to fall and rise again, which needs at least 2×DEBOUNCE_CYCLES cycles between pulses.
- `i_carBarrier` is used directly (it comes from the same clock domain) and is not synchronized.

## Test plan
- Reset, then hold `i_loopEntry`=1 for 10 cycles with `i_carBarrier`=0 → exactly one `o_carIn` pulse at edge k+6. No pulse when the input is released; `o_carOut`=0 throughout.
- `i_loopEntry` glitch high for 3 cycles (DEBOUNCE_CYCLES=4) → no `o_carIn`, filtered value stays 0.
- `i_carBarrier`=1, entry held 10 cycles → no `o_carIn`, `o_violation`=1. `o_violation` stays 1 after the barrier lifts; it returns to 0 only on `i_reset`.
- Boat sequence:
  - far=1 → `o_boat_state`=01, close=1.
  - bridge=1 → 10, here=1.
  - bridge=0 → 11 for exactly 8 cycles.
  - far still 1 → 01.
  - far=0 → 00, all boat outputs 0.
- Retrigger: in CLEARING, assert bridge=1 again → return to PASSING with here continuously 1. Entry and exit loops rising together → `o_carIn` and `o_carOut` in the same cycle.
- Assert `i_reset` mid-CLEARING with entry held high → next cycle all outputs 0 and state 00. After release, one `o_carIn` arrives at full latency.
